// File: rtl/capt_sched_pkg.sv
// capt_sched_pkg: shared types for the capture scheduler.
// FSM state encoding, descriptor record, default header size.
package capt_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        UPDATE
    } state_e;

    typedef struct packed {
        logic [31:0] pkt_begin;
        logic [31:0] pkt_end;
    } desc_t;

    localparam int unsigned HDR_BYTES_DEF = 16;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/capt_sched_if.sv
// capt_sched_if: descriptor handshake from the ingress parser plus
// the start/done bus to wr_ctrl. slave = scheduler, master = environment.
interface capt_sched_if;

    logic        desc_valid;
    logic        desc_ready;
    logic [31:0] desc_begin;
    logic [31:0] desc_end;

    logic        wc_start;
    logic [31:0] wc_pkt_begin;
    logic [31:0] wc_pkt_end;
    logic [31:0] wc_buf_start;
    logic [31:0] wc_buf_size;
    logic        wc_done;
    logic        wc_wrap;

    modport slave (
        input  desc_valid, desc_begin, desc_end,
        input  wc_done, wc_wrap,
        output desc_ready,
        output wc_start, wc_pkt_begin, wc_pkt_end,
        output wc_buf_start, wc_buf_size
    );

    modport master (
        output desc_valid, desc_begin, desc_end,
        output wc_done, wc_wrap,
        input  desc_ready,
        input  wc_start, wc_pkt_begin, wc_pkt_end,
        input  wc_buf_start, wc_buf_size
    );

endinterface

// File: rtl/capt_desc_fifo.sv
// capt_desc_fifo: first-word-fall-through descriptor queue.
// Ports: clk, rst_n (sync, active-low), push_i/din_i, pop_i/dout_o, full_o, empty_o.
module capt_desc_fifo
    import capt_sched_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  push_i,
    input  desc_t din_i,
    input  logic  pop_i,
    output desc_t dout_o,
    output logic  full_o,
    output logic  empty_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    desc_t          mem_q [DEPTH];
    logic [AW-1:0]  wr_q;
    logic [AW-1:0]  rd_q;
    logic [AW:0]    cnt_q;
    logic [AW:0]    cnt_d;
    logic           do_push;
    logic           do_pop;

    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign dout_o  = mem_q[rd_q];

    // A pop frees its slot in the same cycle, so a full queue may push.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        cnt_d = cnt_q;
        if (do_push && !do_pop) cnt_d = cnt_q + 1'b1;
        if (do_pop && !do_push) cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din_i;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/capt_sched.sv
// capt_sched: queues packet descriptors and runs wr_ctrl one packet at a time.
// Ports: clk, reset (sync, active-low), cfg_* from CSR, bus (capt_sched_if.slave),
//   busy, pkt/drop/byte counters, wrap_irq; timeout_err with CAPT_SCHED_WATCHDOG_EN.
module capt_sched
    import capt_sched_pkg::*;
#(
    parameter int unsigned DESC_DEPTH     = 4,
    parameter int unsigned HDR_BYTES      = HDR_BYTES_DEF,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cfg_enable,
    input  logic [31:0] cfg_buf_start,
    input  logic [31:0] cfg_buf_size,
    capt_sched_if.slave bus,
    output logic        busy,
    output logic [31:0] pkt_count,
    output logic [31:0] drop_count,
    output logic [31:0] byte_count,
    output logic        wrap_irq
`ifdef CAPT_SCHED_WATCHDOG_EN
    ,
    output logic        timeout_err
`endif
);

    state_e      state_q;
    state_e      state_d;
    desc_t       head;
    desc_t       din;
    logic        full;
    logic        empty;
    logic        pop;
    logic        timeout;
    logic        rdy_q;
    logic        accept;
    logic        bad;
    logic        push;
    logic [31:0] len;
    logic [1:0]  drop_add;
    logic [32:0] drop_sum;

    logic        wc_start_q;
    logic [31:0] wc_beg_q;
    logic [31:0] wc_end_q;
    logic [31:0] wc_bst_q;
    logic [31:0] wc_bsz_q;
    logic [31:0] pkt_q;
    logic [31:0] drop_q;
    logic [31:0] byte_q;
    logic        wrap_q;
    logic        irq_q;

    // Screening at enqueue; the header sum is 33 bits so it cannot wrap.
    assign len    = bus.desc_end - bus.desc_begin;
    assign accept = bus.desc_valid && bus.desc_ready;
    assign bad    = !cfg_enable
                 || (bus.desc_end <= bus.desc_begin)
                 || (({1'b0, len} + 33'(HDR_BYTES)) > {1'b0, cfg_buf_size});
    assign push   = accept && !bad;

    assign din.pkt_begin = bus.desc_begin;
    assign din.pkt_end   = bus.desc_end;

    capt_desc_fifo #(
        .DEPTH (DESC_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .push_i  (push),
        .din_i   (din),
        .pop_i   (pop),
        .dout_o  (head),
        .full_o  (full),
        .empty_o (empty)
    );

    // rdy_q keeps desc_ready low while reset is held.
    assign bus.desc_ready   = rdy_q && !full;
    assign bus.wc_start     = wc_start_q;
    assign bus.wc_pkt_begin = wc_beg_q;
    assign bus.wc_pkt_end   = wc_end_q;
    assign bus.wc_buf_start = wc_bst_q;
    assign bus.wc_buf_size  = wc_bsz_q;

    assign busy       = (state_q != IDLE) || !empty;
    assign pkt_count  = pkt_q;
    assign drop_count = drop_q;
    assign byte_count = byte_q;
    assign wrap_irq   = irq_q;

`ifdef CAPT_SCHED_WATCHDOG_EN
    localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] wd_q;
`endif

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        timeout = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!empty && cfg_enable) state_d = ISSUE;
            end
            ISSUE: begin
                pop     = 1'b1;
                state_d = WAIT;
            end
            WAIT: begin
                if (bus.wc_done) begin
                    state_d = UPDATE;
`ifdef CAPT_SCHED_WATCHDOG_EN
                end else if (wd_q == WD_LAST) begin
                    state_d = IDLE;
                    timeout = 1'b1;
`endif
                end
            end
            UPDATE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Enqueue drops and watchdog drops may land in the same cycle.
    assign drop_add = {1'b0, accept && bad} + {1'b0, timeout};
    assign drop_sum = {1'b0, drop_q} + {31'd0, drop_add};

    always_ff @(posedge clk) begin
        if (!reset) begin
            rdy_q      <= 1'b0;
            wc_start_q <= 1'b0;
            wc_beg_q   <= '0;
            wc_end_q   <= '0;
            wc_bst_q   <= '0;
            wc_bsz_q   <= '0;
            pkt_q      <= '0;
            drop_q     <= '0;
            byte_q     <= '0;
            wrap_q     <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            rdy_q      <= 1'b1;
            wc_start_q <= (state_d == ISSUE);
            // Load on the way into ISSUE so the bus is valid with wc_start.
            if (state_q == IDLE && state_d == ISSUE) begin
                wc_beg_q <= head.pkt_begin;
                wc_end_q <= head.pkt_end;
                wc_bst_q <= cfg_buf_start;
                wc_bsz_q <= cfg_buf_size;
            end
            if (state_q == UPDATE) begin
                pkt_q  <= sat_inc(pkt_q);
                byte_q <= byte_q + (wc_end_q - wc_beg_q);
            end
            drop_q <= drop_sum[32] ? 32'hFFFF_FFFF : drop_sum[31:0];
            wrap_q <= bus.wc_wrap;
            irq_q  <= bus.wc_wrap && !wrap_q;
        end
    end

`ifdef CAPT_SCHED_WATCHDOG_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            wd_q        <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (state_q == ISSUE)     wd_q <= '0;
            else if (state_q == WAIT) wd_q <= wd_q + 16'd1;
            if (timeout) timeout_err <= 1'b1;
        end
    end
`endif

endmodule
